// File: rtl/km_loader.sv
// km_loader: streaming writer for one IPPro kernel memory.
// Accepts coefficient words on a valid/ready stream and writes them into the
// memory's synchronous write port, starting at a programmed base address and
// wrapping modulo DEPTH. It reports busy/done/error status and a running sum of
// the words it has written.
//
// Ports:
//   KML_CLK, KML_RSTN        clock, asynchronous active-low reset
//   KML_START                start pulse, sampled only while idle
//   KML_BASE, KML_LEN        first address and word count, captured on START
//   KML_S_VALID/READY/DATA   coefficient stream
//   KML_KM_WE/ADDR/DIN       kernel memory write port, one cycle after handshake
//   KML_BUSY, KML_DONE       busy from START until the DONE pulse
//   KML_ERR                  sticky: the last START carried an illegal LEN
//   KML_SUM                  modulo-2^DATA_W sum of words written since START
module km_loader #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
   input  logic              KML_CLK,
   input  logic              KML_RSTN,
   input  logic              KML_START,
   input  logic [ADDR_W-1:0] KML_BASE,
   input  logic [ADDR_W:0]   KML_LEN,
   input  logic              KML_S_VALID,
   input  logic [DATA_W-1:0] KML_S_DATA,
   output logic              KML_S_READY,
   output logic              KML_KM_WE,
   output logic [ADDR_W-1:0] KML_KM_ADDR,
   output logic [DATA_W-1:0] KML_KM_DIN,
   output logic              KML_BUSY,
   output logic              KML_DONE,
   output logic              KML_ERR,
   output logic [DATA_W-1:0] KML_SUM
);

   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   ptr;
   logic [LEN_W-1:0]    rem;
   logic                ready;
   logic                we;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   din;
   logic                busy;
   logic                done;
   logic                err;
   logic [DATA_W-1:0]   sum;

   logic                len_ok;
   logic                hs;
   logic [ADDR_W-1:0]   ptr_next;

   assign len_ok   = (KML_LEN != '0) && (KML_LEN <= LEN_W'(DEPTH));
   assign hs       = KML_S_VALID && ready;
   // Explicit wrap keeps the pointer inside DEPTH.
   assign ptr_next = (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;

   // Load sequencer with all outputs registered.
   always_ff @(posedge KML_CLK or negedge KML_RSTN) begin
      if (!KML_RSTN) begin
         state <= ST_IDLE;
         ptr   <= '0;
         rem   <= '0;
         ready <= 1'b0;
         we    <= 1'b0;
         addr  <= '0;
         din   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         sum   <= '0;
      end else begin
         we   <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (KML_START) begin
                  if (len_ok) begin
                     ptr   <= KML_BASE;
                     rem   <= KML_LEN;
                     sum   <= '0;
                     err   <= 1'b0;
                     ready <= 1'b1;
                     busy  <= 1'b1;
                     state <= ST_LOAD;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (hs) begin
                  we   <= 1'b1;
                  addr <= ptr;
                  din  <= KML_S_DATA;
                  sum  <= sum + KML_S_DATA;
                  ptr  <= ptr_next;
                  rem  <= rem - 1'b1;
                  // Final word: close the stream at this edge so nothing more is taken.
                  if (rem == LEN_W'(1)) begin
                     ready <= 1'b0;
                     state <= ST_FIN;
                  end
               end
            end
            ST_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               ready <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign KML_S_READY = ready;
   assign KML_KM_WE   = we;
   assign KML_KM_ADDR = addr;
   assign KML_KM_DIN  = din;
   assign KML_BUSY    = busy;
   assign KML_DONE    = done;
   assign KML_ERR     = err;
   assign KML_SUM     = sum;

endmodule

// File: tb/tb_km_loader.sv
// tb_km_loader: self-checking bench for km_loader. A transaction-level model
// predicts every output each cycle; directed tests add literal expectations.
module tb_km_loader;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 32;

   logic              KML_CLK = 1'b0;
   logic              KML_RSTN = 1'b0;
   logic              KML_START = 1'b0;
   logic [ADDR_W-1:0] KML_BASE = '0;
   logic [ADDR_W:0]   KML_LEN = '0;
   logic              KML_S_VALID = 1'b0;
   logic [DATA_W-1:0] KML_S_DATA = '0;
   logic              KML_S_READY;
   logic              KML_KM_WE;
   logic [ADDR_W-1:0] KML_KM_ADDR;
   logic [DATA_W-1:0] KML_KM_DIN;
   logic              KML_BUSY;
   logic              KML_DONE;
   logic              KML_ERR;
   logic [DATA_W-1:0] KML_SUM;

   km_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .KML_CLK(KML_CLK), .KML_RSTN(KML_RSTN), .KML_START(KML_START),
      .KML_BASE(KML_BASE), .KML_LEN(KML_LEN), .KML_S_VALID(KML_S_VALID),
      .KML_S_DATA(KML_S_DATA), .KML_S_READY(KML_S_READY), .KML_KM_WE(KML_KM_WE),
      .KML_KM_ADDR(KML_KM_ADDR), .KML_KM_DIN(KML_KM_DIN), .KML_BUSY(KML_BUSY),
      .KML_DONE(KML_DONE), .KML_ERR(KML_ERR), .KML_SUM(KML_SUM)
   );

   always #5 KML_CLK = ~KML_CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // Job = (base, len); word k of the job lands at (base+k) mod DEPTH.
   bit        m_loading = 0;
   bit        m_fin = 0;
   int        m_base = 0, m_len = 0, m_k = 0, m_sum = 0;
   bit        e_ready = 0, e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
   int        e_addr = 0, e_din = 0;

   always @(posedge KML_CLK or negedge KML_RSTN) begin
      if (!KML_RSTN) begin
         m_loading = 0; m_fin = 0; m_base = 0; m_len = 0; m_k = 0; m_sum = 0;
         e_ready = 0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
         e_addr = 0; e_din = 0;
      end else begin
         e_we = 0;
         e_done = 0;
         if (m_fin) begin
            m_fin = 0; e_busy = 0; e_done = 1;
         end else if (m_loading) begin
            if (KML_S_VALID && e_ready) begin
               e_we   = 1;
               e_addr = (m_base + m_k) % DEPTH;
               e_din  = int'(KML_S_DATA);
               m_sum  = (m_sum + int'(KML_S_DATA)) % 65536;
               m_k++;
               if (m_k == m_len) begin
                  m_loading = 0; m_fin = 1; e_ready = 0;
               end
            end
         end else if (KML_START) begin
            if (int'(KML_LEN) >= 1 && int'(KML_LEN) <= DEPTH) begin
               m_base = int'(KML_BASE); m_len = int'(KML_LEN); m_k = 0; m_sum = 0;
               m_loading = 1; e_ready = 1; e_busy = 1; e_err = 0;
            end else begin
               e_err = 1;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of all outputs against the model.
   always @(negedge KML_CLK) begin
      if (KML_RSTN) begin
         chk("s_ready", 32'(KML_S_READY), 32'(e_ready));
         chk("km_we",   32'(KML_KM_WE),   32'(e_we));
         chk("km_addr", 32'(KML_KM_ADDR), 32'(e_addr));
         chk("km_din",  32'(KML_KM_DIN),  32'(e_din));
         chk("busy",    32'(KML_BUSY),    32'(e_busy));
         chk("done",    32'(KML_DONE),    32'(e_done));
         chk("err",     32'(KML_ERR),     32'(e_err));
         chk("sum",     32'(KML_SUM),     32'(m_sum));
      end
   end

   // Log of writes seen on the memory port, plus a shadow memory.
   int                wlog_addr[$];
   int                wlog_din[$];
   logic [DATA_W-1:0] mem [DEPTH];

   always @(negedge KML_CLK) begin
      if (KML_RSTN && KML_KM_WE) begin
         wlog_addr.push_back(int'(KML_KM_ADDR));
         wlog_din.push_back(int'(KML_KM_DIN));
         mem[KML_KM_ADDR] = KML_KM_DIN;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge KML_CLK);
         #1;
      end
   endtask

   task automatic do_start(input int base, input int len);
      KML_BASE  = ADDR_W'(base);
      KML_LEN   = (ADDR_W+1)'(len);
      KML_START = 1'b1;
      step();
      KML_START = 1'b0;
   endtask

   // Present one word after 'gap' idle cycles; returns after its handshake edge.
   task automatic send(input logic [DATA_W-1:0] w, input int gap);
      int t;
      if (gap > 0) begin
         KML_S_VALID = 1'b0;
         KML_S_DATA  = 16'hDEAD;
         step(gap);
      end
      KML_S_VALID = 1'b1;
      KML_S_DATA  = w;
      t = 0;
      while (!KML_S_READY && t < 20) begin
         step();
         t++;
      end
      if (t >= 20) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: ready=%0b required 1", KML_S_READY);
      end
      step();
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!KML_DONE && t < 50) begin
         step();
         t++;
      end
      n_checks++;
      if (t >= 50) begin
         n_errors++;
         $display("FAIL done_timeout: done=%0b required 1", KML_DONE);
      end
   endtask

   task automatic clear_log();
      wlog_addr.delete();
      wlog_din.delete();
   endtask

   initial begin
      // Reset state
      step(2);
      chk("rst_we",    32'(KML_KM_WE),   32'd0);
      chk("rst_busy",  32'(KML_BUSY),    32'd0);
      chk("rst_ready", 32'(KML_S_READY), 32'd0);
      chk("rst_sum",   32'(KML_SUM),     32'd0);
      @(negedge KML_CLK);
      KML_RSTN = 1'b1;
      step(2);

      // Test 1: BASE=0 LEN=4, valid held high
      clear_log();
      do_start(0, 4);
      chk("t1_busy_after_start", 32'(KML_BUSY), 32'd1);
      for (int i = 1; i <= 4; i++) send(DATA_W'(i), 0);
      KML_S_VALID = 1'b0;
      chk("t1_last_we", 32'(KML_KM_WE), 32'd1);
      wait_done();
      chk("t1_sum", 32'(KML_SUM), 32'h000A);
      chk("t1_nwrites", 32'(wlog_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < wlog_addr.size(); i++) begin
         chk("t1_addr", 32'(wlog_addr[i]), 32'(i));
         chk("t1_din",  32'(wlog_din[i]),  32'(i + 1));
      end

      // Test 2: wrap, started back-to-back during another DONE cycle
      step(2);
      do_start(2, 1);
      send(16'h5555, 0);
      KML_S_VALID = 1'b0;
      wait_done();
      clear_log();
      do_start(30, 4);
      for (int i = 0; i < 4; i++) send(16'hA000 + DATA_W'(i), 0);
      KML_S_VALID = 1'b0;
      wait_done();
      chk("t2_sum", 32'(KML_SUM), 32'h8006);
      chk("t2_nwrites", 32'(wlog_addr.size()), 32'd4);
      if (wlog_addr.size() == 4) begin
         chk("t2_a0", 32'(wlog_addr[0]), 32'd30);
         chk("t2_a1", 32'(wlog_addr[1]), 32'd31);
         chk("t2_a2", 32'(wlog_addr[2]), 32'd0);
         chk("t2_a3", 32'(wlog_addr[3]), 32'd1);
      end
      step();
      chk("t2_busy_low", 32'(KML_BUSY), 32'd0);

      // Test 3: LEN=8, valid toggling 1,0,0,1,...
      clear_log();
      do_start(10, 8);
      for (int i = 0; i < 8; i++) send(16'h0100 + DATA_W'(i), (i == 0) ? 0 : 2);
      KML_S_VALID = 1'b0;
      wait_done();
      chk("t3_nwrites", 32'(wlog_addr.size()), 32'd8);
      for (int i = 0; i < 8 && i < wlog_addr.size(); i++)
         chk("t3_addr", 32'(wlog_addr[i]), 32'(10 + i));
      chk("t3_sum", 32'(KML_SUM), 32'h081C);

      // Test 4: illegal lengths, then recovery
      step();
      clear_log();
      do_start(3, 0);
      chk("t4_err_len0", 32'(KML_ERR), 32'd1);
      chk("t4_busy_len0", 32'(KML_BUSY), 32'd0);
      step(2);
      do_start(3, 33);
      chk("t4_err_len33", 32'(KML_ERR), 32'd1);
      chk("t4_busy_len33", 32'(KML_BUSY), 32'd0);
      KML_S_VALID = 1'b1;
      KML_S_DATA  = 16'hBEEF;
      step(3);
      KML_S_VALID = 1'b0;
      chk("t4_no_writes", 32'(wlog_addr.size()), 32'd0);
      do_start(7, 1);
      chk("t4_err_clear", 32'(KML_ERR), 32'd0);
      send(16'h1234, 0);
      KML_S_VALID = 1'b0;
      wait_done();
      chk("t4_one_write", 32'(wlog_addr.size()), 32'd1);
      if (wlog_addr.size() == 1) chk("t4_addr", 32'(wlog_addr[0]), 32'd7);

      // Test 5: LEN=DEPTH from BASE=5, 33rd word refused
      step();
      clear_log();
      do_start(5, 32);
      for (int i = 0; i < 32; i++) send(DATA_W'(i), 0);
      chk("t5_ready_drop", 32'(KML_S_READY), 32'd0);
      KML_S_DATA = 16'h00FF;
      wait_done();
      step(2);
      KML_S_VALID = 1'b0;
      chk("t5_sum", 32'(KML_SUM), 32'h01F0);
      chk("t5_nwrites", 32'(wlog_addr.size()), 32'd32);
      chk("t5_mem5", 32'(mem[5]), 32'd0);
      chk("t5_mem4", 32'(mem[4]), 32'd31);
      chk("t5_mem0", 32'(mem[0]), 32'd27);

      // Test 6: reset mid-load, then a normal job
      step();
      do_start(0, 6);
      for (int i = 0; i < 3; i++) send(16'h0010 + DATA_W'(i), 0);
      KML_RSTN = 1'b0;
      #1;
      chk("t6_we",    32'(KML_KM_WE),   32'd0);
      chk("t6_busy",  32'(KML_BUSY),    32'd0);
      chk("t6_sum",   32'(KML_SUM),     32'd0);
      chk("t6_ready", 32'(KML_S_READY), 32'd0);
      KML_S_VALID = 1'b0;
      @(negedge KML_CLK);
      KML_RSTN = 1'b1;
      step(2);
      clear_log();
      do_start(0, 2);
      send(16'h0011, 0);
      send(16'h0022, 0);
      KML_S_VALID = 1'b0;
      wait_done();
      chk("t6_sum_after", 32'(KML_SUM), 32'h0033);
      chk("t6_nwrites", 32'(wlog_addr.size()), 32'd2);
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/km_loader.md
Name: km_loader

Overview:
- Streaming writer for the kernel memory: accepts coefficient words on a valid/ready stream and drives the memory's synchronous write port (WE, ADDR, DIN).
- Writes a programmed number of words starting at a programmed base address, wrapping modulo the memory depth.
- Sits between the host/configuration path and the kernel memory of each IPPro datapath; reports busy/done/error and a running checksum of the words written.

Parameters:
- DATA_W, 16, width of one kernel memory word (multiple of 8).
- ADDR_W, 5, kernel memory address width.
- DEPTH, 32, kernel memory depth in words (2**ADDR_W).

Ports:
- KML_CLK  in  1  clock; all state changes on rising edge.
- KML_RSTN  in  1  reset, asynchronous assert, active-low.
- KML_START  in  1  start pulse; sampled only in IDLE.
- KML_BASE  in  ADDR_W  first write address; captured on accepted START.
- KML_LEN  in  ADDR_W+1  number of words to load, 1..DEPTH; captured on accepted START.
- KML_S_VALID  in  1  stream word valid.
- KML_S_DATA  in  DATA_W  stream word.
- KML_S_READY  out  1  stream ready.
- KML_KM_WE  out  1  kernel memory write enable.
- KML_KM_ADDR  out  ADDR_W  kernel memory address.
- KML_KM_DIN  out  DATA_W  kernel memory write data.
- KML_BUSY  out  1  high from accepted START until the cycle DONE pulses.
- KML_DONE  out  1  one-cycle pulse after the last write.
- KML_ERR  out  1  sticky: last START had an illegal LEN.
- KML_SUM  out  DATA_W  modulo-2^DATA_W sum of words written since the last accepted START.

Behaviour:
- Reset: state=IDLE; S_READY=0, KM_WE=0, KM_ADDR=0, KM_DIN=0, BUSY=0, DONE=0, ERR=0, SUM=0; internal address and remaining counters = 0.
- States: IDLE, LOAD, FIN.
- IDLE:
  - START with 1<=LEN<=DEPTH: capture BASE into the address pointer and LEN into the remaining counter; clear SUM and ERR; enter LOAD; BUSY=1 from the next cycle.
  - START with LEN=0 or LEN>DEPTH: set ERR=1 and stay in IDLE; BUSY stays 0 and DONE does not pulse.
  - START while not in IDLE is ignored.
- LOAD:
  - S_READY=1 (registered, asserted the cycle LOAD is entered).
  - A handshake is S_VALID&S_READY at a clock edge.
  - Each handshake registers KM_WE=1, KM_ADDR=pointer and KM_DIN=S_DATA for exactly the next cycle, so the memory writes one cycle after the handshake (latency 1).
  - On each handshake: SUM += S_DATA (wraps); pointer = (pointer+1) mod DEPTH; remaining decrements.
  - Cycles without a handshake drive KM_WE=0 and leave KM_ADDR and KM_DIN holding their last values.
  - The handshake that takes remaining from 1 to 0 drops S_READY at the same edge (no extra word accepted) and moves to FIN.
- FIN:
  - Lasts one cycle, which coincides with the final KM_WE=1.
  - At the next edge: DONE=1 for one cycle, BUSY=0, return to IDLE.
  - DONE rises the cycle after the last write.
- Total time for N words with S_VALID held high: START edge -> first write 2 cycles later -> N consecutive WE cycles -> DONE the cycle after the last WE.
- Wrap: BASE=30, LEN=4 writes addresses 30, 31, 0, 1.
- LEN=DEPTH overwrites every location exactly once.
- Back-to-back: START is accepted in the same cycle DONE is high (state already IDLE).
- S_VALID may toggle arbitrarily; S_DATA is only sampled on a handshake.
- SUM and ERR hold until the next accepted START.
- Asserting reset mid-LOAD returns all outputs to reset values immediately. Words already written stay in the memory; no partial-state recovery.

Test Plan:
- Reset, then START BASE=0 LEN=4, stream 0x0001, 0x0002, 0x0003, 0x0004 with S_VALID held high -> WE high 4 consecutive cycles at addresses 0..3 with matching DIN; DONE 1 cycle after the last WE; SUM=0x000A; BUSY low after DONE.
- START BASE=30 LEN=4, data 0xA000..0xA003 -> writes at 30, 31, 0, 1; SUM=0x8006.
- START LEN=8, S_VALID toggling 1,0,0,1,... -> exactly 8 WE pulses, each one cycle after its handshake; no write in gap cycles; address increments only on handshakes.
- START with LEN=0, then START with LEN=33 -> ERR=1 after each, BUSY never asserts, no WE; next START LEN=1 -> ERR clears and one write occurs.
- START LEN=32 BASE=5, data = index -> all 32 addresses written once; SUM=0x01F0; S_READY drops on the 32nd handshake; a 33rd valid word is not accepted.
- Reset asserted after 3 of 6 handshakes -> WE, BUSY, SUM and S_READY go to 0 immediately; after release, START BASE=0 LEN=2 runs normally.
